// File: rtl/scan_ctrl_if.sv
// Bus bundle between the raster-scan sequencer and its environment:
// frame control, X/Y counter control/feedback, and the address handshake
// towards the memory port.
interface scan_ctrl_if #(
    parameter int CNT_WIDTH  = 9,
    parameter int ADDR_WIDTH = 17
);
    logic                  start;
    logic                  abort;
    logic [CNT_WIDTH-1:0]  x_cnt;
    logic [CNT_WIDTH-1:0]  y_cnt;
    logic                  pix_ready;
    logic                  x_en;
    logic                  x_sclr;
    logic                  y_en;
    logic                  y_sclr;
    logic                  addr_valid;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  line_done;
    logic                  busy;
    logic                  done;

    // Sequencer side
    modport master (
        input  start, abort, x_cnt, y_cnt, pix_ready,
        output x_en, x_sclr, y_en, y_sclr, addr_valid, addr_out,
               line_done, busy, done
    );

    // Environment side (counters, memory port, frame controller)
    modport slave (
        output start, abort, x_cnt, y_cnt, pix_ready,
        input  x_en, x_sclr, y_en, y_sclr, addr_valid, addr_out,
               line_done, busy, done
    );
endinterface

// File: rtl/scan_ctrl.sv
// Raster-scan sequencer for the X/Y address counter pair of the deskew
// datapath. Steps the counters through a frame, presents the linear pixel
// address y*IMG_W+x with a valid/ready handshake, optionally idles HBLANK
// cycles between lines and pulses done at the end of the frame.
module scan_ctrl #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int HBLANK     = 0,
    parameter int CNT_WIDTH  = 9,
    parameter int ADDR_WIDTH = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    scan_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  X_LAST   = CNT_WIDTH'(IMG_W - 1);
    localparam logic [CNT_WIDTH-1:0]  Y_LAST   = CNT_WIDTH'(IMG_H - 1);
    localparam logic [7:0]            GAP_LAST = 8'((HBLANK > 0) ? (HBLANK - 1) : 0);
    localparam logic [ADDR_WIDTH-1:0] LINE_LEN = ADDR_WIDTH'(IMG_W);

    state_t                state_q;
    state_t                state_d;
    logic [7:0]            gap_cnt_q;
    logic [7:0]            gap_cnt_d;

    logic                  x_end_s;
    logic                  y_end_s;
    logic [ADDR_WIDTH-1:0] lin_addr_s;
    logic                  x_en_s;
    logic                  x_sclr_s;
    logic                  y_en_s;
    logic                  y_sclr_s;
    logic                  addr_valid_s;
    logic [ADDR_WIDTH-1:0] addr_out_s;
    logic                  line_done_s;
    logic                  done_s;

    // Out-of-range counts are folded into end-of-line / end-of-frame.
    assign x_end_s    = (bus.x_cnt >= X_LAST);
    assign y_end_s    = (bus.y_cnt >= Y_LAST);
    assign lin_addr_s = (ADDR_WIDTH'(bus.y_cnt) * LINE_LEN) + ADDR_WIDTH'(bus.x_cnt);

    // State and gap counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic and counter/handshake controls; abort overrides everything outside IDLE.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        x_en_s       = 1'b0;
        x_sclr_s     = 1'b0;
        y_en_s       = 1'b0;
        y_sclr_s     = 1'b0;
        addr_valid_s = 1'b0;
        addr_out_s   = '0;
        line_done_s  = 1'b0;
        done_s       = 1'b0;

        if ((state_q != ST_IDLE) && bus.abort) begin
            // Park the counters at zero so the next frame starts clean.
            x_sclr_s  = 1'b1;
            y_sclr_s  = 1'b1;
            gap_cnt_d = 8'd0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_CLEAR: begin
                    x_sclr_s = 1'b1;
                    y_sclr_s = 1'b1;
                    state_d  = ST_SCAN;
                end

                ST_SCAN: begin
                    addr_valid_s = 1'b1;
                    addr_out_s   = lin_addr_s;
                    if (bus.pix_ready) begin
                        if (!x_end_s) begin
                            x_en_s = 1'b1;
                        end else begin
                            line_done_s = 1'b1;
                            x_sclr_s    = 1'b1;
                            if (y_end_s) begin
                                y_sclr_s = 1'b1;
                                state_d  = ST_DONE;
                            end else begin
                                y_en_s = 1'b1;
                                if (HBLANK > 0) begin
                                    gap_cnt_d = 8'd0;
                                    state_d   = ST_GAP;
                                end else begin
                                    state_d = ST_SCAN;
                                end
                            end
                        end
                    end else begin
                        // Stalled: counters hold, so addr_out holds too.
                        state_d = ST_SCAN;
                    end
                end

                ST_GAP: begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_GAP;
                    end
                end

                ST_DONE: begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end

                default: begin
                    gap_cnt_d = 8'd0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.x_en       = x_en_s;
    assign bus.x_sclr     = x_sclr_s;
    assign bus.y_en       = y_en_s;
    assign bus.y_sclr     = y_sclr_s;
    assign bus.addr_valid = addr_valid_s;
    assign bus.addr_out   = addr_out_s;
    assign bus.line_done  = line_done_s;
    assign bus.done       = done_s;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: two instances (HBLANK=0 and HBLANK=2) on a 4x3 image,
// each with its own X/Y counter models. Stimulus pushes expected addresses
// and done events into per-instance queues; one monitor checks them.
module tb_scan_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 9;
    localparam int AW = 17;

    typedef struct {
        bit            is_done;
        logic [AW-1:0] addr;
        bit            line;
        int            cyc;
    } item_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic          start_i [2];
    logic          abort_i [2];
    logic          ready_i [2];
    logic          valid_o [2];
    logic          line_o  [2];
    logic          busy_o  [2];
    logic          done_o  [2];
    logic          xen_o   [2];
    logic          yen_o   [2];
    logic          xs_o    [2];
    logic          ys_o    [2];
    logic [AW-1:0] addr_o  [2];

    item_t exp_q [2][$];
    int    busy_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [CW-1:0] x_q;
        logic [CW-1:0] y_q;

        scan_ctrl_if #(.CNT_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

        assign bus.start     = start_i[g];
        assign bus.abort     = abort_i[g];
        assign bus.pix_ready = ready_i[g];
        assign bus.x_cnt     = x_q;
        assign bus.y_cnt     = y_q;
        assign valid_o[g]    = bus.addr_valid;
        assign addr_o[g]     = bus.addr_out;
        assign line_o[g]     = bus.line_done;
        assign busy_o[g]     = bus.busy;
        assign done_o[g]     = bus.done;
        assign xen_o[g]      = bus.x_en;
        assign yen_o[g]      = bus.y_en;
        assign xs_o[g]       = bus.x_sclr;
        assign ys_o[g]       = bus.y_sclr;

        // X/Y counter models with their own asynchronous reset.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x_q <= '0;
                y_q <= '0;
            end else begin
                if (bus.x_sclr)     x_q <= '0;
                else if (bus.x_en)  x_q <= x_q + 9'd1;
                if (bus.y_sclr)     y_q <= '0;
                else if (bus.y_en)  y_q <= y_q + 9'd1;
            end
        end

        scan_ctrl #(
            .IMG_W(W), .IMG_H(H), .HBLANK((g == 0) ? 0 : 2),
            .CNT_WIDTH(CW), .ADDR_WIDTH(AW)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: compare every presented address / done pulse against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int g = 0; g < 2; g++) begin
                if (busy_o[g]) busy_cnt[g] <= busy_cnt[g] + 1;
                if (valid_o[g]) begin
                    if (exp_q[g].size() == 0 || exp_q[g][0].is_done) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut%0d unexpected_valid: got addr %0d, expected no valid (cycle %0d)",
                                 g, addr_o[g], cyc);
                    end else begin
                        check($sformatf("dut%0d addr", g), 32'(addr_o[g]), 32'(exp_q[g][0].addr));
                        if (ready_i[g]) begin
                            check($sformatf("dut%0d line_done", g), 32'(line_o[g]), 32'(exp_q[g][0].line));
                            if (exp_q[g][0].cyc >= 0)
                                check($sformatf("dut%0d addr_cycle", g), 32'(cyc), 32'(exp_q[g][0].cyc));
                            void'(exp_q[g].pop_front());
                        end else begin
                            check($sformatf("dut%0d stall_en", g), 32'(xen_o[g] | yen_o[g]), 32'd0);
                        end
                    end
                end
                if (done_o[g]) begin
                    if (exp_q[g].size() == 0 || !exp_q[g][0].is_done) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut%0d unexpected_done: got done=1, expected 0 (cycle %0d)", g, cyc);
                    end else begin
                        if (exp_q[g][0].cyc >= 0)
                            check($sformatf("dut%0d done_cycle", g), 32'(cyc), 32'(exp_q[g][0].cyc));
                        void'(exp_q[g].pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected sequence for a frame started at cycle c (c<0: untimed).
    task automatic push_frame(input int g, input int c, input int gap, input int n_addr, input bit with_done);
        item_t it;
        for (int k = 0; k < n_addr; k++) begin
            it.is_done = 1'b0;
            it.addr    = AW'(k);
            it.line    = ((k % W) == (W - 1));
            it.cyc     = (c < 0) ? -1 : (c + 2 + k + gap * (k / W));
            exp_q[g].push_back(it);
        end
        if (with_done) begin
            it.is_done = 1'b1;
            it.addr    = '0;
            it.line    = 1'b0;
            it.cyc     = (c < 0) ? -1 : (c + 2 + W * H + gap * (H - 1));
            exp_q[g].push_back(it);
        end
    endtask

    task automatic start_frame(input int g, input bit timed, input int n_addr, input bit with_done, output int c);
        int gap;
        gap = (g == 0) ? 0 : 2;
        c   = cyc;
        push_frame(g, timed ? c : -1, gap, n_addr, with_done);
        start_i[g] = 1'b1;
        step();
        start_i[g] = 1'b0;
    endtask

    task automatic wait_empty(input int g, input int bound);
        int n;
        n = 0;
        while (exp_q[g].size() != 0 && n < bound) begin
            step();
            n++;
        end
        check($sformatf("dut%0d drain_timeout", g), 32'(exp_q[g].size()), 32'd0);
    endtask

    task automatic check_idle(input int g, input string tag);
        check($sformatf("dut%0d %s valid", g, tag), 32'(valid_o[g]), 32'd0);
        check($sformatf("dut%0d %s addr",  g, tag), 32'(addr_o[g]),  32'd0);
        check($sformatf("dut%0d %s ctrl",  g, tag),
              32'({xen_o[g], yen_o[g], xs_o[g], ys_o[g], line_o[g], done_o[g]}), 32'd0);
        check($sformatf("dut%0d %s busy",  g, tag), 32'(busy_o[g]), 32'd0);
    endtask

    initial begin
        int c;
        int b0;
        logic pat [4];
        int k;
        int n;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int g = 0; g < 2; g++) begin
            start_i[g]  = 1'b0;
            abort_i[g]  = 1'b0;
            ready_i[g]  = 1'b1;
            busy_cnt[g] = 0;
        end

        // Reset state
        @(negedge clk);
        check_idle(0, "reset");
        check_idle(1, "reset");
        step();
        rst_n = 1'b1;
        step();

        // 1) HBLANK=0: 0..11 back to back, done after addr 11, busy 14 cycles
        b0 = busy_cnt[0];
        start_frame(0, 1'b1, W * H, 1'b1, c);
        wait_empty(0, 60);
        step();
        step();
        check("dut0 busy_cycles", 32'(busy_cnt[0] - b0), 32'd14);

        // 2) HBLANK=2: two-cycle gaps after addr 3 and 7, done 4 cycles later
        b0 = busy_cnt[1];
        start_frame(1, 1'b1, W * H, 1'b1, c);
        wait_empty(1, 60);
        step();
        step();
        check("dut1 busy_cycles", 32'(busy_cnt[1] - b0), 32'd18);

        // 3) pix_ready 1,0,0,1,... : addresses held while stalled
        start_frame(1, 1'b0, W * H, 1'b1, c);
        k = 0;
        n = 0;
        while (exp_q[1].size() != 0 && n < 200) begin
            ready_i[1] = pat[k % 4];
            step();
            k++;
            n++;
        end
        ready_i[1] = 1'b1;
        check("dut1 stall_drain", 32'(exp_q[1].size()), 32'd0);
        step();

        // 4) abort while addr 6 is presented
        start_frame(1, 1'b1, 6, 1'b0, c);
        while (cyc < c + 10) step();
        check("abort_at_addr", 32'(addr_o[1]), 32'd6);
        abort_i[1] = 1'b1;
        @(negedge clk);
        check("abort sclr", 32'({xs_o[1], ys_o[1]}), 32'd3);
        check("abort gated", 32'({valid_o[1], xen_o[1], yen_o[1], line_o[1], done_o[1]}), 32'd0);
        step();
        abort_i[1] = 1'b0;
        @(negedge clk);
        check("abort busy_next", 32'(busy_o[1]), 32'd0);
        check("abort leftover", 32'(exp_q[1].size()), 32'd0);
        repeat (4) step();
        start_frame(1, 1'b1, W * H, 1'b1, c);
        wait_empty(1, 60);
        step();

        // 5) start with abort in IDLE stays idle; start mid-frame is ignored
        start_i[1] = 1'b1;
        abort_i[1] = 1'b1;
        step();
        start_i[1] = 1'b0;
        abort_i[1] = 1'b0;
        step();
        @(negedge clk);
        check("start_abort busy", 32'(busy_o[1]), 32'd0);
        step();
        start_frame(1, 1'b1, W * H, 1'b1, c);
        repeat (5) step();
        start_i[1] = 1'b1;
        step();
        start_i[1] = 1'b0;
        wait_empty(1, 60);
        repeat (5) step();
        @(negedge clk);
        check("midstart busy", 32'(busy_o[1]), 32'd0);
        step();

        // 6) asynchronous reset mid-SCAN
        start_frame(1, 1'b1, W * H, 1'b1, c);
        while (cyc < c + 5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle(1, "async_rst");
        exp_q[1].delete();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("post_rst busy", 32'(busy_o[1]), 32'd0);
        check("post_rst valid", 32'(valid_o[1]), 32'd0);
        step();
        start_frame(1, 1'b1, W * H, 1'b1, c);
        wait_empty(1, 60);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
